// File: rtl/pll_seq_pkg.sv
// Purpose: shared types and default constants for the PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_seq_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

  // Width of a counter that runs 0..bound-1; never narrower than one bit.
  function automatic int cnt_width(input int bound);
    return (bound < 2) ? 1 : $clog2(bound);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Purpose: generic two-flop synchronizer for a single asynchronous level.
// Latency: two destination clock cycles.
// Backpressure: none; the level is sampled every cycle.
module bit_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first one a full cycle to resolve.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Purpose: pulses the PLL reset, qualifies lock, releases system reset, retries/fails.
// Latency: locked->lock_s 2 cycles; sys_rst_n rises STABLE_CYCLES+3 after locked.
// Backpressure: none; relock_req is a single-cycle pulse honoured in every state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                               i_refclk,
  input  logic                               i_rst_n,
  input  logic                               i_locked,
  input  logic                               i_relock_req,
  output logic                               o_pll_rst,
  output logic                               o_sys_rst_n,
  output logic                               o_running,
  output logic                               o_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
  output logic [7:0]                         o_lock_loss_cnt
);

  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);
  localparam int PULSE_W   = cnt_width(RST_CYCLES);
  // Stable and timeout phases never overlap, so one timer serves both.
  localparam int TMR_BOUND = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int TMR_W     = cnt_width(TMR_BOUND);

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STB_LAST   = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  pll_seq_state_t       r_state;
  pll_seq_state_t       w_state_nxt;
  logic [PULSE_W-1:0]   r_pulse_cnt;
  logic [PULSE_W-1:0]   w_pulse_nxt;
  logic [TMR_W-1:0]     r_tmr_cnt;
  logic [TMR_W-1:0]     w_tmr_nxt;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic [RETRY_W-1:0]   w_retry_nxt;
  logic [RETRY_W-1:0]   w_retry_inc;
  logic [7:0]           r_loss_cnt;
  logic [7:0]           w_loss_nxt;
  logic                 r_pll_rst;
  logic                 r_sys_rst_n;
  logic                 r_running;
  logic                 r_fail;
  logic                 w_lock_s;

  bit_sync u_lock_sync (
    .i_clk   (i_refclk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (w_lock_s)
  );

  assign w_retry_inc = r_retry_cnt + 1'b1;

  // Next-state and next-counter decode; relock_req overrides everything last.
  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = r_pulse_cnt;
    w_tmr_nxt   = r_tmr_cnt;
    w_retry_nxt = r_retry_cnt;
    w_loss_nxt  = r_loss_cnt;

    case (r_state)
      RESET_PLL: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_tmr_nxt   = '0;
        end else begin
          w_pulse_nxt = r_pulse_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr_cnt == TMO_LAST) begin
          w_retry_nxt = w_retry_inc;
          if (w_retry_inc == RETRY_MAX) begin
            w_state_nxt = FAIL;
          end else begin
            w_state_nxt = RESET_PLL;
            w_pulse_nxt = '0;
          end
        end else begin
          w_tmr_nxt = r_tmr_cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_tmr_nxt   = '0;
        end else if (r_tmr_cnt == STB_LAST) begin
          w_state_nxt = RUN;
          w_retry_nxt = '0;
        end else begin
          w_tmr_nxt = r_tmr_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = RESET_PLL;
          w_pulse_nxt = '0;
        end
      end
      FAIL: begin
        w_state_nxt = FAIL;
      end
      default: begin
        w_state_nxt = RESET_PLL;
        w_pulse_nxt = '0;
      end
    endcase

    // Lock loss in RUN counts once, even when a relock arrives the same cycle.
    if ((r_state == RUN) && !w_lock_s && (r_loss_cnt != 8'hFF)) begin
      w_loss_nxt = r_loss_cnt + 8'd1;
    end

    if (i_relock_req) begin
      w_state_nxt = RESET_PLL;
      w_pulse_nxt = '0;
      w_retry_nxt = '0;
    end
  end

  // State, counters and Moore outputs registered from the decoded next state.
  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RESET_PLL;
      r_pulse_cnt <= '0;
      r_tmr_cnt   <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_running   <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_nxt;
      r_tmr_cnt   <= w_tmr_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_loss_cnt  <= w_loss_nxt;
      r_pll_rst   <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
      r_sys_rst_n <= (w_state_nxt == RUN);
      r_running   <= (w_state_nxt == RUN);
      r_fail      <= (w_state_nxt == FAIL);
    end
  end

  assign o_pll_rst       = r_pll_rst;
  assign o_sys_rst_n     = r_sys_rst_n;
  assign o_running       = r_running;
  assign o_fail          = r_fail;
  assign o_retry_cnt     = r_retry_cnt;
  assign o_lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed + random check of pll_reset_sequencer against a timestamp reference model.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: n/a.
module tb_pll_reset_sequencer;

  localparam int RST = 4;
  localparam int TO  = 20;
  localparam int STB = 8;
  localparam int MR  = 2;

  localparam int M_PULSE = 0;
  localparam int M_WAIT  = 1;
  localparam int M_QUAL  = 2;
  localparam int M_RUN   = 3;
  localparam int M_DEAD  = 4;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       relock_req;
  logic       o_pll_rst;
  logic       o_sys_rst_n;
  logic       o_running;
  logic       o_fail;
  logic [1:0] o_retry_cnt;
  logic [7:0] o_lock_loss_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: phase plus the edge number at which it began.
  int m_ph;
  int m_start;
  int m_retry;
  int m_loss;
  int tnow;
  bit lk_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (MR)
  ) dut (
    .i_refclk        (refclk),
    .i_rst_n         (rst_n),
    .i_locked        (locked),
    .i_relock_req    (relock_req),
    .o_pll_rst       (o_pll_rst),
    .o_sys_rst_n     (o_sys_rst_n),
    .o_running       (o_running),
    .o_fail          (o_fail),
    .o_retry_cnt     (o_retry_cnt),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", tnow);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, tnow, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph    = M_PULSE;
    m_start = 0;
    m_retry = 0;
    m_loss  = 0;
    tnow    = 0;
    lk_q    = {1'b0, 1'b0};
  endtask

  // A decision at edge t is based on the locked level sampled two edges earlier.
  task automatic model_edge(input bit lk_in, input bit rq);
    bit seen;
    tnow++;
    lk_q.push_back(lk_in);
    seen = lk_q[lk_q.size() - 3];
    if (lk_q.size() > 4) lk_q.delete(0);
    if (rq) begin
      if (m_ph == M_RUN && !seen && m_loss < 255) m_loss++;
      m_ph    = M_PULSE;
      m_start = tnow;
      m_retry = 0;
    end else begin
      case (m_ph)
        M_PULSE: if (tnow - m_start == RST) begin m_ph = M_WAIT; m_start = tnow; end
        M_WAIT: begin
          if (seen) begin
            m_ph = M_QUAL; m_start = tnow;
          end else if (tnow - m_start == TO) begin
            m_retry++;
            if (m_retry == MR) m_ph = M_DEAD;
            else begin m_ph = M_PULSE; m_start = tnow; end
          end
        end
        M_QUAL: begin
          if (!seen) begin m_ph = M_WAIT; m_start = tnow; end
          else if (tnow - m_start == STB) begin m_ph = M_RUN; m_retry = 0; end
        end
        M_RUN: begin
          if (!seen) begin
            if (m_loss < 255) m_loss++;
            m_ph = M_PULSE; m_start = tnow;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("pll_rst",       o_pll_rst,       32'((m_ph == M_PULSE) || (m_ph == M_DEAD)));
    chk("sys_rst_n",     o_sys_rst_n,     32'(m_ph == M_RUN));
    chk("running",       o_running,       32'(m_ph == M_RUN));
    chk("fail",          o_fail,          32'(m_ph == M_DEAD));
    chk("retry_cnt",     o_retry_cnt,     32'(m_retry));
    chk("lock_loss_cnt", o_lock_loss_cnt, 32'(m_loss));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pll_rst"},   o_pll_rst,       32'd1);
    chk({tag, "_sys_rst_n"}, o_sys_rst_n,     32'd0);
    chk({tag, "_running"},   o_running,       32'd0);
    chk({tag, "_fail"},      o_fail,          32'd0);
    chk({tag, "_retry"},     o_retry_cnt,     32'd0);
    chk({tag, "_loss"},      o_lock_loss_cnt, 32'd0);
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge refclk);
    if (rst_n) model_edge(locked, relock_req);
    @(negedge refclk);
    if (rst_n) check_all();
  endtask

  task automatic run_to(input int c);
    while (tnow < c) cyc();
  endtask

  initial begin
    int hold;
    int b;
    rst_n      = 1'b0;
    locked     = 1'b0;
    relock_req = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    check_reset_values("por");
    rst_n = 1'b1;
    model_reset();
    check_all();

    // Nominal bring-up: locked rises during cycle 10.
    run_to(3);  chk("nom_pll_c3", o_pll_rst, 32'd1);
    run_to(4);  chk("nom_pll_c4", o_pll_rst, 32'd0);
    run_to(10); locked = 1'b1;
    run_to(20); chk("nom_sys_c20", o_sys_rst_n, 32'd0);
    run_to(21); chk("nom_sys_c21", o_sys_rst_n, 32'd1);
    chk("nom_run_c21", o_running, 32'd1);

    // Lock loss in RUN, then no lock: two timeouts lead to FAIL.
    run_to(30); locked = 1'b0;
    run_to(32); chk("loss_sys_c32", o_sys_rst_n, 32'd1);
    run_to(33); chk("loss_sys_c33", o_sys_rst_n, 32'd0);
    chk("loss_pll_c33", o_pll_rst, 32'd1);
    chk("loss_cnt_c33", o_lock_loss_cnt, 32'd1);
    run_to(56); chk("to_retry_c56", o_retry_cnt, 32'd0);
    run_to(57); chk("to_retry_c57", o_retry_cnt, 32'd1);
    chk("to_pll_c57", o_pll_rst, 32'd1);
    run_to(60); chk("to_pll_c60", o_pll_rst, 32'd1);
    run_to(61); chk("to_pll_c61", o_pll_rst, 32'd0);
    run_to(80); chk("to_fail_c80", o_fail, 32'd0);
    run_to(81); chk("to_fail_c81", o_fail, 32'd1);
    chk("to_retry_c81", o_retry_cnt, 32'd2);
    chk("to_pll_c81", o_pll_rst, 32'd1);
    run_to(90); chk("fail_hold_c90", o_fail, 32'd1);

    // relock_req from FAIL: single pulse, retry cleared.
    relock_req = 1'b1; cyc(); relock_req = 1'b0;
    chk("rl_fail_retry", o_retry_cnt, 32'd0);
    chk("rl_fail_fail", o_fail, 32'd0);
    run_to(94); chk("rl_pll_c94", o_pll_rst, 32'd1);
    run_to(95); chk("rl_pll_c95", o_pll_rst, 32'd0);

    // Unstable lock: high 5 cycles, low 1, then high for good.
    locked = 1'b1;
    run_to(100); locked = 1'b0;
    run_to(101); locked = 1'b1;
    run_to(106); chk("unst_abort_c106", o_running, 32'd0);
    run_to(111); chk("unst_sys_c111", o_sys_rst_n, 32'd0);
    run_to(112); chk("unst_sys_c112", o_sys_rst_n, 32'd1);

    // relock_req coinciding with lock loss in RUN.
    run_to(120); locked = 1'b0;
    run_to(122); relock_req = 1'b1; cyc(); relock_req = 1'b0; locked = 1'b1;
    chk("sim_loss_cnt", o_lock_loss_cnt, 32'd2);
    chk("sim_pll", o_pll_rst, 32'd1);
    chk("sim_retry", o_retry_cnt, 32'd0);
    run_to(126); chk("sim_pll_c126", o_pll_rst, 32'd1);
    run_to(127); chk("sim_pll_c127", o_pll_rst, 32'd0);
    run_to(136); chk("sim_run_c136", o_running, 32'd1);
    chk("sim_loss_c136", o_lock_loss_cnt, 32'd2);

    // relock_req inside RESET_PLL extends the pulse.
    run_to(145); relock_req = 1'b1; cyc(); relock_req = 1'b0;
    run_to(147); relock_req = 1'b1; cyc(); relock_req = 1'b0;
    run_to(150); chk("ext_pll_c150", o_pll_rst, 32'd1);
    run_to(151); chk("ext_pll_c151", o_pll_rst, 32'd1);
    run_to(152); chk("ext_pll_c152", o_pll_rst, 32'd0);

    // rst_n asserted mid-STABLE, then released with lock still present.
    run_to(156); chk("mid_stable_run", o_running, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    model_reset();
    check_all();
    run_to(12); chk("rst2_sys_c12", o_sys_rst_n, 32'd0);
    run_to(13); chk("rst2_sys_c13", o_sys_rst_n, 32'd1);

    // Random locked waveforms and occasional relock requests.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        locked = ~locked;
        hold = int'($urandom_range(1, 30));
      end
      hold--;
      relock_req = ($urandom_range(0, 63) == 0);
      cyc();
    end
    relock_req = 1'b0;

    // Drive repeated lock losses until the loss counter saturates.
    relock_req = 1'b1; cyc(); relock_req = 1'b0;
    locked = 1'b1;
    for (int i = 0; i < 260; i++) begin
      b = 0;
      while (!o_running && b < 100) begin cyc(); b++; end
      chk("sat_reach_run", o_running, 32'd1);
      locked = 1'b0;
      b = 0;
      while (o_running && b < 10) begin cyc(); b++; end
      chk("sat_leave_run", o_running, 32'd0);
      locked = 1'b1;
    end
    repeat (5) cyc();
    chk("loss_saturated", o_lock_loss_cnt, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
